// File: rtl/kalman_update_sequencer.sv
// Scalar Kalman predict/update sequencer driving one shared single-precision add/sub/mul/div port.
// Eight ops per measurement; x/P/K commit together only when the last result lands.
module kalman_update_sequencer #(
    parameter logic [31:0] X0      = 32'h00000000,
    parameter logic [31:0] P0      = 32'h3e99999a,
    parameter int          TIMEOUT = 64,
    parameter int          CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             z_valid,
    input  logic [31:0]      z_data,
    output logic             z_ready,
    input  logic [31:0]      q_cfg,
    input  logic [31:0]      r_cfg,
    output logic             op_valid,
    output logic [1:0]       op_code,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    input  logic             res_valid,
    input  logic [31:0]      res_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      x_out,
    output logic [31:0]      p_out,
    output logic [31:0]      k_out,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
    localparam logic [31:0] ONE = 32'h3f800000;

    // ISSUE_n/WAIT_n are folded into ISSUE/WAIT plus a step index (0..7).
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_next;
    logic [2:0]       step;
    logic [31:0]      z_r, q_r, r_r, x_r, p_r, k_r;
    logic [31:0]      tmp [8];  // pp, s, k, e, t, x_new, omk, p_new
    logic [WD_W-1:0]  wd;
    logic [CNT_W-1:0] iter;
    logic             res_take, wd_expired;
    logic [1:0]       sel_code;
    logic [31:0]      sel_a, sel_b;

    // A result in the same cycle as the issue strobe cannot belong to this op.
    assign res_take   = (state == WAIT) && res_valid && !op_valid;
    assign wd_expired = (state == WAIT) && (wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        sel_code = OP_ADD;
        sel_a    = p_r;
        sel_b    = q_r;
        case (step)
            3'd0: begin sel_code = OP_ADD; sel_a = p_r;    sel_b = q_r;    end
            3'd1: begin sel_code = OP_ADD; sel_a = tmp[0]; sel_b = r_r;    end
            3'd2: begin sel_code = OP_DIV; sel_a = tmp[0]; sel_b = tmp[1]; end
            3'd3: begin sel_code = OP_SUB; sel_a = z_r;    sel_b = x_r;    end
            3'd4: begin sel_code = OP_MUL; sel_a = tmp[2]; sel_b = tmp[3]; end
            3'd5: begin sel_code = OP_ADD; sel_a = x_r;    sel_b = tmp[4]; end
            3'd6: begin sel_code = OP_SUB; sel_a = ONE;    sel_b = tmp[2]; end
            3'd7: begin sel_code = OP_MUL; sel_a = tmp[6]; sel_b = tmp[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (z_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (res_take)        state_next = (step == 3'd7) ? DONE : ISSUE;
                else if (wd_expired) state_next = IDLE;
            end
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            step        <= 3'd0;
            wd          <= '0;
            x_r         <= X0;
            p_r         <= P0;
            k_r         <= '0;
            iter        <= '0;
            err_timeout <= 1'b0;
            op_valid    <= 1'b0;
            op_code     <= OP_ADD;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            state    <= state_next;
            op_valid <= 1'b0;
            case (state)
                IDLE: if (z_valid) begin
                    z_r  <= z_data;
                    q_r  <= q_cfg;
                    r_r  <= r_cfg;
                    step <= 3'd0;
                end
                ISSUE: begin
                    op_valid <= 1'b1;
                    op_code  <= sel_code;
                    op_a     <= sel_a;
                    op_b     <= sel_b;
                    wd       <= '0;
                end
                WAIT: begin
                    if (res_take) begin
                        tmp[step] <= res_data;
                        step      <= step + 3'd1;
                        if (step == 3'd7) begin
                            x_r <= tmp[5];
                            p_r <= res_data;
                            k_r <= tmp[2];
                        end
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                DONE: if (out_ready) iter <= iter + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign z_ready   = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign x_out     = x_r;
    assign p_out     = p_r;
    assign k_out     = k_r;
    assign iter_cnt  = iter;
endmodule
